// File: rtl/lcd_text_ctrl.sv
// lcd_text_ctrl: HD44780-style character LCD controller with a host-written text buffer.
// Ports:
//   clk, rst                  single clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data   host character write, wr_addr = row*COLS+col
//   init_done                 power-up command sequence complete
//   busy                      init or repaint in progress (or repaint pending)
//   rs, rw, en, dout          LCD register select, read/write (always 0), enable, data bus
module lcd_text_ctrl #(
   parameter int CLK_HZ = 22118400,
   parameter int ROWS   = 4,
   parameter int COLS   = 20,
   parameter int AW     = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   output logic          init_done,
   output logic          busy,
   output logic          rs,
   output logic          rw,
   output logic          en,
   output logic [7:0]    dout
);
   localparam longint HZ     = longint'(CLK_HZ);
   localparam int     D_PWR  = int'((HZ * 41 + 9999) / 10000);
   localparam int     D_100  = int'((HZ + 9999) / 10000);
   localparam int     D_40   = int'((HZ * 4 + 99999) / 100000);
   localparam int     D_CLR  = int'((HZ * 164 + 99999) / 100000);
   localparam int     EN_RAW = int'((HZ + 1999999) / 2000000);
   localparam int     EN_CYC = (EN_RAW < 1) ? 1 : EN_RAW;
   localparam int     CNTW   = $clog2(D_PWR + 1);
   localparam int     RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int     CW     = $clog2(COLS);
   localparam int     NCH    = ROWS * COLS;

   typedef enum logic [1:0] {INIT, IDLE, ROWADDR, CHAR} state_t;
   // P_LOAD is the launch point after reset and the resting phase in IDLE
   typedef enum logic [1:0] {P_LOAD, P_SETUP, P_PULSE, P_WAIT} phase_t;

   state_t          state_q;
   phase_t          ph_q;
   logic [2:0]      step_q;
   logic [RW-1:0]   row_q;
   logic [CW-1:0]   col_q;
   logic [CNTW-1:0] cnt_q;
   logic [7:0]      buf_q [2**AW];
   logic            dirty_q, dirty_d;
   logic            rs_q, en_q, init_done_q;
   logic [7:0]      dout_q;
   logic            wr_ok, go, cnt_end, last_col, last_row;
   logic [AW-1:0]   rd_idx;
   int              dly;
   logic [CNTW-1:0] delay_m1;

   function automatic logic [7:0] cmd_of(input logic [2:0] s);
      return (s < 3'd3) ? 8'h38 : (s == 3'd3) ? 8'h06 : (s == 3'd4) ? 8'h0C : 8'h01;
   endfunction

   function automatic logic [7:0] row_base(input logic [1:0] r);
      return r[1] ? (r[0] ? 8'hD4 : 8'h94) : (r[0] ? 8'hC0 : 8'h80);
   endfunction

   always_comb begin
      wr_ok    = wr_en && (int'(wr_addr) < NCH);
      go       = (state_q == IDLE) && dirty_q;
      // a write landing in the go cycle keeps dirty set so it gets painted
      dirty_d  = wr_ok || (dirty_q && !go);
      cnt_end  = cnt_q == '0;
      last_col = col_q == CW'(COLS - 1);
      last_row = row_q == RW'(ROWS - 1);
      // index of the character sent by the transfer that follows the current one
      rd_idx   = AW'(int'(row_q) * COLS + ((state_q == CHAR) ? int'(col_q) + 1 : 0));
      dly      = (state_q != INIT) ? D_40 : (step_q == 3'd0) ? D_PWR :
                 (step_q == 3'd1) ? D_100 : (step_q == 3'd5) ? D_CLR : D_40;
      delay_m1 = CNTW'(dly - 1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dirty_q <= 1'b1;
         for (int i = 0; i < 2**AW; i++) buf_q[i] <= 8'h20;
      end else begin
         dirty_q <= dirty_d;
         if (wr_ok) buf_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= INIT;
         ph_q        <= P_LOAD;
         step_q      <= '0;
         row_q       <= '0;
         col_q       <= '0;
         cnt_q       <= '0;
         rs_q        <= 1'b0;
         en_q        <= 1'b0;
         dout_q      <= 8'h00;
         init_done_q <= 1'b0;
      end else begin
         case (ph_q)
            P_LOAD: begin
               if (state_q == INIT) begin
                  ph_q   <= P_SETUP;
                  rs_q   <= 1'b0;
                  dout_q <= cmd_of(step_q);
               end else if (go) begin
                  state_q <= ROWADDR;
                  ph_q    <= P_SETUP;
                  row_q   <= '0;
                  rs_q    <= 1'b0;
                  dout_q  <= 8'h80;
               end
            end
            P_SETUP: begin
               ph_q  <= P_PULSE;
               en_q  <= 1'b1;
               cnt_q <= CNTW'(EN_CYC - 1);
            end
            P_PULSE: begin
               if (cnt_end) begin
                  ph_q  <= P_WAIT;
                  en_q  <= 1'b0;
                  cnt_q <= delay_m1;
               end else cnt_q <= cnt_q - 1'b1;
            end
            default: begin
               if (!cnt_end) cnt_q <= cnt_q - 1'b1;
               else begin
                  // the next transfer's SETUP starts on the edge that ends this WAIT
                  ph_q <= P_SETUP;
                  case (state_q)
                     INIT: begin
                        if (step_q == 3'd5) begin
                           state_q     <= IDLE;
                           ph_q        <= P_LOAD;
                           init_done_q <= 1'b1;
                        end else begin
                           step_q <= step_q + 3'd1;
                           dout_q <= cmd_of(step_q + 3'd1);
                        end
                     end
                     ROWADDR: begin
                        state_q <= CHAR;
                        col_q   <= '0;
                        rs_q    <= 1'b1;
                        dout_q  <= buf_q[rd_idx];
                     end
                     CHAR: begin
                        if (!last_col) begin
                           col_q  <= col_q + 1'b1;
                           dout_q <= buf_q[rd_idx];
                        end else if (!last_row) begin
                           state_q <= ROWADDR;
                           row_q   <= row_q + 1'b1;
                           rs_q    <= 1'b0;
                           dout_q  <= row_base(2'(row_q) + 2'd1);
                        end else begin
                           state_q <= IDLE;
                           ph_q    <= P_LOAD;
                        end
                     end
                     default: ph_q <= P_LOAD;
                  endcase
               end
            end
         endcase
      end
   end

   assign rs        = rs_q;
   assign rw        = 1'b0;
   assign en        = en_q;
   assign dout      = dout_q;
   assign init_done = init_done_q;
   assign busy      = (state_q != IDLE) || dirty_q;
endmodule

// File: tb/tb_lcd_text_ctrl.sv
// tb_lcd_text_ctrl: scoreboard bench for lcd_text_ctrl (1 MHz clock, 2x16 display).
module tb_lcd_text_ctrl;
   localparam int ROWS = 2;
   localparam int COLS = 16;
   localparam int AW   = 6;
   localparam int NCH  = ROWS * COLS;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [7:0]    wr_data = '0;
   logic          init_done, busy, rs, rw, en;
   logic [7:0]    dout;

   typedef struct {bit rs; int d; int gap; bit mk;} xfer_t;
   xfer_t sb[$];
   int    mdl [NCH];
   int    n_tests = 0;
   int    n_fail = 0;
   int    cyc = 0;
   int    mark = 0;
   int    seen = 0;
   int    pushed = 0;

   lcd_text_ctrl #(.CLK_HZ(1000000), .ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .init_done(init_done), .busy(busy), .rs(rs), .rw(rw), .en(en), .dout(dout)
   );

   always #5 clk = ~clk;

   initial forever @(posedge clk) cyc++;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push1(input bit r, input int d, input int g, input bit m);
      xfer_t x;
      x.rs = r;
      x.d = d;
      x.gap = g;
      x.mk = m;
      sb.push_back(x);
      pushed++;
   endtask

   task automatic push_repaint(input int g0, input bit m0);
      for (int r = 0; r < ROWS; r++) begin
         push1(1'b0, (r == 0) ? 'h80 : 'hC0, (r == 0) ? g0 : 42, (r == 0) ? m0 : 1'b0);
         for (int c = 0; c < COLS; c++) push1(1'b1, mdl[r * COLS + c], 42, 1'b0);
      end
   endtask

   task automatic push_init();
      push1(1'b0, 'h38, 2, 1'b1);
      push1(1'b0, 'h38, 4102, 1'b0);
      push1(1'b0, 'h38, 102, 1'b0);
      push1(1'b0, 'h06, 42, 1'b0);
      push1(1'b0, 'h0C, 42, 1'b0);
      push1(1'b0, 'h01, 42, 1'b0);
      push_repaint(1643, 1'b0);
   endtask

   task automatic flush();
      pushed -= sb.size();
      sb.delete();
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(sb.size() == 0 && !busy) && n < budget);
      check({tag, "_done"}, int'(sb.size() == 0 && !busy), 1);
      check({tag, "_count"}, seen, pushed);
   endtask

   task automatic idle_check(input string tag, input int n);
      int h = 0;
      repeat (n) begin
         @(negedge clk);
         h += int'(busy);
      end
      check({tag, "_busy"}, h, 0);
      check({tag, "_count"}, seen, pushed);
   endtask

   task automatic wr1(input int a, input int d);
      if (a < NCH) mdl[a] = d;
      wr_en = 1'b1;
      wr_addr = AW'(a);
      wr_data = 8'(d);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // pulse monitor: pops one expected transfer per en rising edge
   initial begin
      xfer_t it;
      int last_p = 0;
      logic prev_en = 1'b0;
      logic prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (en && !prev_en) begin
            seen++;
            check("rw", int'(rw), 0);
            if (sb.size() > 0) begin
               it = sb.pop_front();
               check($sformatf("rs_%0d", seen), int'(rs), int'(it.rs));
               check($sformatf("dout_%0d", seen), int'(dout), it.d);
               check($sformatf("gap_%0d", seen), cyc - (it.mk ? mark : last_p), it.gap);
            end
            last_p = cyc;
         end
         prev_en = en;
         if (init_done && !prev_done) check("init_done_lat", cyc - last_p, 1641);
         prev_done = init_done;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, base;
      foreach (mdl[i]) mdl[i] = 'h20;
      repeat (3) @(negedge clk);
      check("rst_rs", int'(rs), 0);
      check("rst_rw", int'(rw), 0);
      check("rst_en", int'(en), 0);
      check("rst_dout", int'(dout), 0);
      check("rst_init_done", int'(init_done), 0);
      check("rst_busy", int'(busy), 1);
      push_init();
      mark = cyc;
      rst = 1'b0;
      drain("init", 9000);
      check("init_done", int'(init_done), 1);
      idle_check("idle0", 100);

      // back-to-back "HI": the second write lands in the IDLE->ROWADDR cycle
      mdl[16] = 'h48;
      mdl[17] = 'h49;
      push_repaint(3, 1'b1);
      push_repaint(43, 1'b0);
      mark = cyc;
      wr_en = 1'b1;
      wr_addr = AW'(16);
      wr_data = 8'h48;
      @(negedge clk);
      wr_addr = AW'(17);
      wr_data = 8'h49;
      @(negedge clk);
      wr_en = 1'b0;
      check("dirty_set_wins", int'(dut.dirty_q), 1);
      check("busy_repaint", int'(busy), 1);
      drain("hi", 5000);
      idle_check("idle_hi", 100);

      // out-of-range writes are dropped; last valid index still paints
      wr1(40, 'h41);
      wr1(32, 'h42);
      idle_check("oor", 200);
      mdl[31] = 'h21;
      push_repaint(3, 1'b1);
      mark = cyc;
      wr1(31, 'h21);
      drain("last_addr", 3000);
      idle_check("idle_last", 100);

      // write during the 10th character of a repaint
      mdl[0] = 'h41;
      push_repaint(3, 1'b1);
      base = seen;
      mark = cyc;
      wr1(0, 'h41);
      n = 0;
      while (seen < base + 11 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("tenth_char_reached", int'(seen - base >= 11), 1);
      mdl[5] = 'h5A;
      push_repaint(43, 1'b0);
      wr1(5, 'h5A);
      drain("mid", 5000);
      idle_check("idle_mid", 300);

      // reset during the en pulse of init step 4
      rst = 1'b1;
      @(negedge clk);
      flush();
      foreach (mdl[i]) mdl[i] = 'h20;
      push_init();
      mark = cyc;
      rst = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(en && dout == 8'h06) && n < 8000);
      check("step4_reached", int'(en && dout == 8'h06), 1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_en", int'(en), 0);
      check("rst_mid_dout", int'(dout), 0);
      check("rst_mid_busy", int'(busy), 1);
      check("rst_mid_init_done", int'(init_done), 0);
      flush();
      @(negedge clk);
      push_init();
      mark = cyc;
      rst = 1'b0;
      drain("restart", 9000);
      idle_check("idle_restart", 100);

      check("total_pulses", seen, pushed);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
